// File: rtl/boot_pkg.sv
// Shared types and helpers for the parametrised boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    LOAD_RX,
    LOAD_WR,
    LOAD_SUM,
    RUN,
    SCAN_RD,
    SCAN_WAIT,
    SCAN_TX,
    SCAN_SUM
  } state_e;

  localparam logic [7:0] RELOAD_BYTE_DEF = 8'hB0;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/boot_loader_param_if.sv
// Byte-stream (rx/tx) and RAM port bundle seen by the boot loader.
interface boot_loader_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;
  logic              ram_rw;
  logic              ram_enable;

  modport master (
    input  rx_data, rx_valid, tx_ready, ram_out,
    output rx_ready, tx_data, tx_valid, ram_adr, ram_in, ram_rw, ram_enable
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, ram_out,
    input  rx_ready, tx_data, tx_valid, ram_adr, ram_in, ram_rw, ram_enable
  );
endinterface

// File: rtl/boot_word_shifter.sv
// Byte-wide shift register for one RAM word: assembles bytes MSB-first on load
// and serialises a parallel-loaded word MSB-first on scan.
module boot_word_shifter
  import boot_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              clr,
  input  logic              load_en,
  input  logic              shift_in_en,
  input  logic              shift_out_en,
  input  logic [DATA_W-1:0] load_word,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic [7:0]        byte_out,
  output logic              last
);
  localparam int BYTES = bytes_of(DATA_W);
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] word_d, word_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  assign word     = word_q;
  assign byte_out = word_q[DATA_W-1 -: 8];
  assign last     = (cnt_q == CNT_W'(BYTES - 1));

  // Byte counter wraps on the last byte so the next word starts clean.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load_en) begin
      word_d = load_word;
      cnt_d  = '0;
    end else if (shift_in_en || shift_out_en) begin
      word_d = (word_q << 8) | (shift_in_en ? DATA_W'(byte_in) : '0);
      cnt_d  = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (ce) begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/boot_loader_param.sv
// Boot loader: fills program RAM from the rx byte stream, dumps it on a scan
// request, and reports an 8-bit checksum after each load or dump.
module boot_loader_param
  import boot_pkg::*;
#(
  parameter int         DATA_W      = 16,
  parameter int         ADDR_W      = 6,
  parameter int         DEPTH       = 64,
  parameter int         RD_LAT      = 1,
  parameter logic [7:0] RELOAD_BYTE = RELOAD_BYTE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic scan_memory,
  output logic boot,
  boot_loader_param_if.master bus
);
  localparam int                WAIT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] adr_d, adr_q;
  logic [7:0]        sum_d, sum_q;
  logic [WAIT_W-1:0] wait_d, wait_q;
  logic              scan_q;
  logic              rx_en_q;

  logic              rx_fire, tx_fire, scan_rise;
  logic              sh_clr, sh_load, sh_in, sh_out, sh_last;
  logic [DATA_W-1:0] sh_word;
  logic [7:0]        sh_byte;

  assign rx_fire   = bus.rx_valid && bus.rx_ready && ce;
  assign tx_fire   = bus.tx_valid && bus.tx_ready && ce;
  assign scan_rise = scan_memory && !scan_q;

  boot_word_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .clr          (sh_clr),
    .load_en      (sh_load),
    .shift_in_en  (sh_in),
    .shift_out_en (sh_out),
    .load_word    (bus.ram_out),
    .byte_in      (bus.rx_data),
    .word         (sh_word),
    .byte_out     (sh_byte),
    .last         (sh_last)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    sum_d   = sum_q;
    wait_d  = wait_q;
    sh_clr  = 1'b0;
    sh_load = 1'b0;
    sh_in   = 1'b0;
    sh_out  = 1'b0;
    unique case (state_q)
      LOAD_RX: begin
        if (rx_fire) begin
          sh_in = 1'b1;
          sum_d = sum_q + bus.rx_data;
          if (sh_last) state_d = LOAD_WR;
        end
      end
      LOAD_WR: begin
        if (adr_q == LAST_ADR) begin
          state_d = LOAD_SUM;
        end else begin
          adr_d   = adr_q + 1'b1;
          state_d = LOAD_RX;
        end
      end
      LOAD_SUM: begin
        if (tx_fire) state_d = RUN;
      end
      RUN: begin
        // A reload byte takes priority over a coincident scan edge.
        if (rx_fire && (bus.rx_data == RELOAD_BYTE)) begin
          adr_d   = '0;
          sum_d   = '0;
          sh_clr  = 1'b1;
          state_d = LOAD_RX;
        end else if (scan_rise) begin
          adr_d   = '0;
          sum_d   = '0;
          sh_clr  = 1'b1;
          state_d = SCAN_RD;
        end
      end
      SCAN_RD: begin
        wait_d  = '0;
        state_d = SCAN_WAIT;
      end
      SCAN_WAIT: begin
        if (wait_q == WAIT_W'(RD_LAT - 1)) begin
          sh_load = 1'b1;
          state_d = SCAN_TX;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      SCAN_TX: begin
        if (tx_fire) begin
          sh_out = 1'b1;
          sum_d  = sum_q + sh_byte;
          if (sh_last) begin
            if (adr_q == LAST_ADR) begin
              state_d = SCAN_SUM;
            end else begin
              adr_d   = adr_q + 1'b1;
              state_d = SCAN_RD;
            end
          end
        end
      end
      SCAN_SUM: begin
        if (tx_fire) state_d = RUN;
      end
      default: state_d = LOAD_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_RX;
      adr_q   <= '0;
      sum_q   <= '0;
      wait_q  <= '0;
      scan_q  <= 1'b0;
      rx_en_q <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      adr_q   <= adr_d;
      sum_q   <= sum_d;
      wait_q  <= wait_d;
      scan_q  <= scan_memory;
      rx_en_q <= 1'b1;
    end
  end

  // rx_en_q keeps rx_ready low for the cycle straight after reset.
  assign boot           = (state_q != RUN);
  assign bus.rx_ready   = rx_en_q && ((state_q == LOAD_RX) || (state_q == RUN));
  assign bus.tx_valid   = (state_q == LOAD_SUM) || (state_q == SCAN_TX) || (state_q == SCAN_SUM);
  assign bus.tx_data    = (state_q == SCAN_TX) ? sh_byte :
                          ((state_q == LOAD_SUM) || (state_q == SCAN_SUM)) ? sum_q : 8'h00;
  assign bus.ram_enable = (state_q == LOAD_WR) || (state_q == SCAN_RD);
  assign bus.ram_rw     = (state_q == LOAD_WR);
  assign bus.ram_adr    = adr_q;
  assign bus.ram_in     = (state_q == LOAD_WR) ? sh_word : '0;

endmodule

// File: tb/tb_boot_loader_param.sv
// Bench for boot_loader_param: a 16-bit/64-word instance and a 32-bit/4-word
// instance with two-cycle read latency, each against a small RAM model.
module tb_boot_loader_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, ce_a, scan_a, boot_a;
  logic rst_b, ce_b, scan_b, boot_b;

  boot_loader_param_if #(.DATA_W(16), .ADDR_W(6)) ifa ();
  boot_loader_param_if #(.DATA_W(32), .ADDR_W(3)) ifb ();

  boot_loader_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .RD_LAT(1), .RELOAD_BYTE(8'hB0)) dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a), .scan_memory(scan_a), .boot(boot_a), .bus(ifa));
  boot_loader_param #(.DATA_W(32), .ADDR_W(3), .DEPTH(4), .RD_LAT(2), .RELOAD_BYTE(8'hB0)) dut_b (
    .clk(clk), .rst(rst_b), .ce(ce_b), .scan_memory(scan_b), .boot(boot_b), .bus(ifb));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM models: ce-qualified, read data valid RD_LAT cycles after the strobe,
  // junk on every other cycle so a mistimed capture shows up.
  logic [15:0] mem_a [64];
  logic [15:0] rd_a;
  always @(posedge clk) if (ce_a) begin
    if (ifa.ram_enable && ifa.ram_rw) mem_a[ifa.ram_adr] <= ifa.ram_in;
    rd_a <= (ifa.ram_enable && !ifa.ram_rw) ? mem_a[ifa.ram_adr] : 16'hDEAD;
  end
  assign ifa.ram_out = rd_a;

  logic [31:0] mem_b [8];
  logic [31:0] pipe_b0, pipe_b1;
  always @(posedge clk) if (ce_b) begin
    if (ifb.ram_enable && ifb.ram_rw) mem_b[ifb.ram_adr] <= ifb.ram_in;
    pipe_b0 <= (ifb.ram_enable && !ifb.ram_rw) ? mem_b[ifb.ram_adr] : 32'hA5A5_5A5A;
    pipe_b1 <= pipe_b0;
  end
  assign ifb.ram_out = pipe_b1;

  // Scoreboards: expectations queued at stimulus time, popped on DUT output.
  logic [21:0] wexp_a [$];
  logic [7:0]  txq_a  [$];
  logic [34:0] wexp_b [$];
  logic [7:0]  txq_b  [$];

  always @(negedge clk) if (!rst_a) begin
    if (ce_a && ifa.ram_enable && ifa.ram_rw) begin
      if (wexp_a.size() == 0) chk("wr_a_extra", ifa.ram_enable, 0);
      else chk("wr_a", {ifa.ram_adr, ifa.ram_in}, wexp_a.pop_front());
    end
    if (ce_a && ifa.tx_valid && ifa.tx_ready) begin
      if (txq_a.size() == 0) chk("tx_a_extra", ifa.tx_valid, 0);
      else chk("tx_a", ifa.tx_data, txq_a.pop_front());
    end
    if (!boot_a) chk("run_a_no_ram", ifa.ram_enable, 0);
  end

  always @(negedge clk) if (!rst_b) begin
    if (ce_b && ifb.ram_enable && ifb.ram_rw) begin
      if (wexp_b.size() == 0) chk("wr_b_extra", ifb.ram_enable, 0);
      else chk("wr_b", {ifb.ram_adr, ifb.ram_in}, wexp_b.pop_front());
    end
    if (ce_b && ifb.tx_valid && ifb.tx_ready) begin
      if (txq_b.size() == 0) chk("tx_b_extra", ifb.tx_valid, 0);
      else chk("tx_b", ifb.tx_data, txq_b.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    int n = 0;
    ifa.rx_data  = b;
    ifa.rx_valid = 1'b1;
    while (!(ifa.rx_ready && ce_a) && n < 100) begin tick(); n++; end
    if (n >= 100) chk("rx_a_timeout", ifa.rx_ready, 1);
    tick();
    ifa.rx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    int n = 0;
    ifb.rx_data  = b;
    ifb.rx_valid = 1'b1;
    while (!(ifb.rx_ready && ce_b) && n < 100) begin tick(); n++; end
    if (n >= 100) chk("rx_b_timeout", ifb.rx_ready, 1);
    tick();
    ifb.rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] rx;
    logic       exp_boot;
    logic       exp_rdy;
  } vec_t;
  vec_t vt [6];

  logic [7:0]  sum_m, kb, held;
  logic [15:0] w16;
  logic [31:0] wb [4];
  int n, bad;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) mem_b[i] <= 32'hC0DE_0000 | i;
    vt[0] = '{8'h12, 1'b0, 1'b1};
    vt[1] = '{8'hB1, 1'b0, 1'b1};
    vt[2] = '{8'hAF, 1'b0, 1'b1};
    vt[3] = '{8'h00, 1'b0, 1'b1};
    vt[4] = '{8'hFF, 1'b0, 1'b1};
    vt[5] = '{8'hB0, 1'b1, 1'b1};
    wb[0] = 32'h0123_4567; wb[1] = 32'h89AB_CDEF; wb[2] = 32'hFEDC_BA98; wb[3] = 32'h3C5A_96E1;

    rst_a = 1'b1; ce_a = 1'b1; scan_a = 1'b0;
    ifa.rx_valid = 1'b0; ifa.rx_data = 8'h00; ifa.tx_ready = 1'b0;
    rst_b = 1'b1; ce_b = 1'b1; scan_b = 1'b0;
    ifb.rx_valid = 1'b0; ifb.rx_data = 8'h00; ifb.tx_ready = 1'b1;
    repeat (3) tick();

    // Reset values
    chk("rst_boot", boot_a, 1);
    chk("rst_rx_ready", ifa.rx_ready, 0);
    chk("rst_tx_valid", ifa.tx_valid, 0);
    chk("rst_tx_data", ifa.tx_data, 0);
    chk("rst_ram_enable", ifa.ram_enable, 0);
    chk("rst_ram_rw", ifa.ram_rw, 0);
    chk("rst_ram_adr", ifa.ram_adr, 0);
    chk("rst_ram_in", ifa.ram_in, 0);
    rst_a = 1'b0;
    tick();
    chk("rx_ready_after_rst", ifa.rx_ready, 1);

    // Full load: word k = {k, ~k}
    sum_m = 8'h00;
    for (int k = 0; k < 64; k++) begin
      kb = k[7:0];
      w16 = {kb, ~kb};
      wexp_a.push_back({k[5:0], w16});
      sum_m = sum_m + kb + ~kb;
      send_a(kb);
      send_a(~kb);
      if (k == 0) chk("wr_latency", {ifa.ram_enable, ifa.ram_rw}, 2'b11);
    end
    txq_a.push_back(sum_m);
    n = 0;
    while (!ifa.tx_valid && n < 50) begin tick(); n++; end
    chk("sum_a_valid", ifa.tx_valid, 1);
    chk("sum_a_data", ifa.tx_data, sum_m);
    chk("sum_a_boot_held", boot_a, 1);
    ifa.tx_ready = 1'b1;
    tick();
    chk("boot_a_fall", boot_a, 0);
    chk("load_a_drain", wexp_a.size() + txq_a.size(), 0);

    // Scan dump with a tx stall and ce toggling
    sum_m = 8'h00;
    for (int k = 0; k < 64; k++) begin
      kb = k[7:0];
      txq_a.push_back(kb);
      txq_a.push_back(~kb);
      sum_m = sum_m + kb + ~kb;
    end
    txq_a.push_back(sum_m);
    scan_a = 1'b1;
    tick();
    chk("scan_a_boot", boot_a, 1);
    n = 0;
    while (!(ifa.tx_valid && txq_a.size() <= 100) && n < 500) begin tick(); n++; end
    chk("stall_a_valid", ifa.tx_valid, 1);
    held = ifa.tx_data;
    ifa.tx_ready = 1'b0;
    scan_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ce_a = 1'($urandom_range(0, 1));
      tick();
      chk("stall_a_data", ifa.tx_data, held);
      chk("stall_a_valid_hold", ifa.tx_valid, 1);
    end
    ifa.tx_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ce_a = 1'($urandom_range(0, 1));
      scan_a = (i >= 5 && i < 10);
      tick();
    end
    ce_a = 1'b1;
    n = 0; bad = 0;
    while (!(txq_a.size() == 0 && !boot_a) && n < 3000) begin
      if (!boot_a && txq_a.size() != 0) bad++;
      tick(); n++;
    end
    chk("scan_a_drain", txq_a.size(), 0);
    chk("scan_a_boot_held", bad, 0);
    chk("scan_a_done_boot", boot_a, 0);

    // RUN-mode byte table; last entry is the reload byte
    for (int i = 0; i < 6; i++) begin
      send_a(vt[i].rx);
      chk("vec_boot", boot_a, vt[i].exp_boot);
      chk("vec_rdy", ifa.rx_ready, vt[i].exp_rdy);
    end
    chk("reload_adr", ifa.ram_adr, 0);

    // Three words, then reset mid-load
    sum_m = 8'h00;
    for (int k = 0; k < 3; k++) begin
      kb = 8'(k * 3 + 1);
      w16 = {kb, kb ^ 8'h5A};
      wexp_a.push_back({k[5:0], w16});
      send_a(w16[15:8]);
      send_a(w16[7:0]);
    end
    tick();
    rst_a = 1'b1;
    tick();
    chk("midrst_boot", boot_a, 1);
    chk("midrst_tx_valid", ifa.tx_valid, 0);
    chk("midrst_rx_ready", ifa.rx_ready, 0);
    chk("midrst_adr", ifa.ram_adr, 0);
    rst_a = 1'b0;
    tick();

    // Fresh load after reset: must start at adr 0 with a zero sum
    sum_m = 8'h00;
    for (int k = 0; k < 64; k++) begin
      kb = 8'(k * 7 + 3);
      w16 = {kb, kb ^ 8'hC3};
      wexp_a.push_back({k[5:0], w16});
      sum_m = sum_m + w16[15:8] + w16[7:0];
      send_a(w16[15:8]);
      send_a(w16[7:0]);
    end
    txq_a.push_back(sum_m);
    n = 0;
    while (boot_a && n < 100) begin tick(); n++; end
    chk("reload_a_boot", boot_a, 0);
    chk("reload_a_drain", wexp_a.size() + txq_a.size(), 0);

    // Reload byte and scan edge in the same cycle: reload wins
    ifa.rx_data = 8'hB0;
    ifa.rx_valid = 1'b1;
    scan_a = 1'b1;
    tick();
    ifa.rx_valid = 1'b0;
    chk("both_boot", boot_a, 1);
    chk("both_rdy", ifa.rx_ready, 1);
    chk("both_ram_enable", ifa.ram_enable, 0);
    scan_a = 1'b0;
    tick(); tick();
    chk("both_tx_valid", ifa.tx_valid, 0);

    // 32-bit instance, RD_LAT=2, DEPTH=4
    rst_b = 1'b0;
    tick();
    chk("b_rx_ready", ifb.rx_ready, 1);
    sum_m = 8'h00;
    for (int k = 0; k < 4; k++) begin
      wexp_b.push_back({k[2:0], wb[k]});
      for (int j = 3; j >= 0; j--) begin
        sum_m = sum_m + wb[k][8*j +: 8];
        send_b(wb[k][8*j +: 8]);
      end
    end
    txq_b.push_back(sum_m);
    n = 0;
    while (boot_b && n < 100) begin tick(); n++; end
    chk("load_b_boot", boot_b, 0);
    chk("load_b_drain", wexp_b.size() + txq_b.size(), 0);

    sum_m = 8'h00;
    for (int k = 0; k < 4; k++) begin
      for (int j = 3; j >= 0; j--) begin
        sum_m = sum_m + wb[k][8*j +: 8];
        txq_b.push_back(wb[k][8*j +: 8]);
      end
    end
    txq_b.push_back(sum_m);
    scan_b = 1'b1;
    tick();
    chk("scan_b_boot", boot_b, 1);
    scan_b = 1'b0;
    n = 0;
    while (!(txq_b.size() == 0 && !boot_b) && n < 2000) begin
      ce_b = 1'($urandom_range(0, 1));
      tick(); n++;
    end
    ce_b = 1'b1;
    chk("scan_b_drain", txq_b.size(), 0);
    chk("scan_b_done_boot", boot_b, 0);
    for (int i = 4; i < 8; i++) chk("b_upper_untouched", mem_b[i], 32'hC0DE_0000 | i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
